// File: rtl/mem_arbiter_n.sv
// Byte-serial memory controller: arbitrates NUM_CH burst requesters onto the 8-bit RAM/UART bus.
// Supports fixed or round-robin grant, read cancel (rollback) and UART-full write stalls.
module mem_arbiter_n #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned MAX_BYTES = 16,
   parameter int unsigned LEN_W     = 5,
   parameter int unsigned ARB_RR    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic [7:0]                    mem_din,
   output logic [7:0]                    mem_dout,
   output logic [31:0]                   mem_a,
   output logic                          mem_wr,
   input  logic                          io_buffer_full,
   input  logic [NUM_CH-1:0]             ch_req,
   input  logic [NUM_CH-1:0]             ch_wr,
   input  logic [NUM_CH-1:0]             ch_cancel,
   input  logic [NUM_CH*32-1:0]          ch_addr,
   input  logic [NUM_CH*LEN_W-1:0]       ch_len,
   input  logic [NUM_CH*MAX_BYTES*8-1:0] ch_wdata,
   output logic [NUM_CH-1:0]             ch_done,
   output logic [MAX_BYTES*8-1:0]        ch_rdata
);
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DATA_W = MAX_BYTES * 8;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t              state, state_d;
   logic [CH_W-1:0]     gnt, gnt_d, rr_ptr, rr_ptr_d;
   logic [31:0]         b_addr, b_addr_d;
   logic [LEN_W-1:0]    b_len, b_len_d, cnt, cnt_d;
   logic [DATA_W-1:0]   b_wdata, b_wdata_d;
   logic                wr_act, wr_act_d;
   logic [7:0]          mem_dout_d;
   logic [31:0]         mem_a_d;
   logic                mem_wr_d;
   logic [NUM_CH-1:0]   ch_done_d;
   logic [DATA_W-1:0]   ch_rdata_d;

   logic [NUM_CH-1:0]   elig;
   logic                any_e, hi_e, found;
   logic [CH_W-1:0]     lo_sel, hi_sel, sel;
   logic [31:0]         sel_addr;
   logic [LEN_W-1:0]    sel_len_raw, sel_len;
   logic                sel_issue;
   logic [LEN_W-1:0]    nxt_idx;
   logic [31:0]         nxt_a;
   logic                issue;

   assign elig = ch_req & ~ch_cancel;

   // Lowest eligible index at or above rr_ptr, else lowest overall (fixed mode: rr_ptr ignored)
   always_comb begin
      any_e  = 1'b0;
      hi_e   = 1'b0;
      lo_sel = '0;
      hi_sel = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (elig[i]) begin
            any_e  = 1'b1;
            lo_sel = CH_W'(i);
            if ((ARB_RR == 0) || (CH_W'(i) >= rr_ptr)) begin
               hi_e   = 1'b1;
               hi_sel = CH_W'(i);
            end
         end
      end
      found       = any_e;
      sel         = hi_e ? hi_sel : lo_sel;
      sel_addr    = ch_addr[int'(sel)*32 +: 32];
      sel_len_raw = ch_len[int'(sel)*LEN_W +: LEN_W];
      sel_len     = (sel_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len_raw;
      sel_issue   = !((sel_addr[17:16] == 2'b11) && io_buffer_full);
   end

   always_comb begin
      state_d    = state;
      gnt_d      = gnt;
      rr_ptr_d   = rr_ptr;
      b_addr_d   = b_addr;
      b_len_d    = b_len;
      b_wdata_d  = b_wdata;
      cnt_d      = cnt;
      wr_act_d   = 1'b0;
      mem_a_d    = '0;
      mem_wr_d   = 1'b0;
      mem_dout_d = mem_dout;
      ch_done_d  = '0;
      ch_rdata_d = ch_rdata;
      nxt_idx    = '0;
      nxt_a      = '0;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_d     = sel;
               rr_ptr_d  = (int'(sel) == int'(NUM_CH) - 1) ? '0 : sel + CH_W'(1);
               b_addr_d  = sel_addr;
               b_len_d   = sel_len;
               b_wdata_d = ch_wdata[int'(sel)*DATA_W +: DATA_W];
               cnt_d     = '0;
               if (!ch_wr[sel]) ch_rdata_d = '0;
               if (sel_len == '0) begin
                  state_d        = DONE;
                  ch_done_d[sel] = 1'b1;
               end else if (ch_wr[sel]) begin
                  state_d    = WRITE;
                  mem_a_d    = sel_addr;
                  mem_dout_d = ch_wdata[int'(sel)*DATA_W +: 8];
                  mem_wr_d   = sel_issue;
                  wr_act_d   = sel_issue;
               end else begin
                  state_d = READ;
                  mem_a_d = sel_addr;
               end
            end
         end
         // Address k goes out at count k; its data returns and is captured at count k+1
         READ: begin
            if (ch_cancel[gnt]) begin
               state_d = IDLE;
            end else begin
               if (cnt != '0) ch_rdata_d[int'(cnt - LEN_W'(1))*8 +: 8] = mem_din;
               if (cnt == b_len) begin
                  state_d        = DONE;
                  ch_done_d[gnt] = 1'b1;
               end else begin
                  cnt_d = cnt + LEN_W'(1);
                  if (cnt_d < b_len) mem_a_d = b_addr + 32'(cnt_d);
               end
            end
         end
         // wr_act marks that byte cnt was issued last cycle; otherwise it is retried
         WRITE: begin
            if (wr_act && ((cnt + LEN_W'(1)) == b_len)) begin
               state_d        = DONE;
               ch_done_d[gnt] = 1'b1;
            end else begin
               nxt_idx    = wr_act ? cnt + LEN_W'(1) : cnt;
               nxt_a      = b_addr + 32'(nxt_idx);
               issue      = !((nxt_a[17:16] == 2'b11) && io_buffer_full);
               cnt_d      = nxt_idx;
               mem_a_d    = nxt_a;
               mem_dout_d = b_wdata[int'(nxt_idx)*8 +: 8];
               mem_wr_d   = issue;
               wr_act_d   = issue;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         rr_ptr   <= '0;
         b_addr   <= '0;
         b_len    <= '0;
         b_wdata  <= '0;
         cnt      <= '0;
         wr_act   <= 1'b0;
         mem_a    <= '0;
         mem_wr   <= 1'b0;
         mem_dout <= '0;
         ch_done  <= '0;
         ch_rdata <= '0;
      end else if (rdy) begin
         state    <= state_d;
         gnt      <= gnt_d;
         rr_ptr   <= rr_ptr_d;
         b_addr   <= b_addr_d;
         b_len    <= b_len_d;
         b_wdata  <= b_wdata_d;
         cnt      <= cnt_d;
         wr_act   <= wr_act_d;
         mem_a    <= mem_a_d;
         mem_wr   <= mem_wr_d;
         mem_dout <= mem_dout_d;
         ch_done  <= ch_done_d;
         ch_rdata <= ch_rdata_d;
      end else begin
         mem_wr  <= 1'b0;
         ch_done <= '0;
      end
   end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a fixed-priority 2-channel instance and a round-robin 3-channel instance
// sharing one clock, each fed by a one-cycle-latency RAM model.
module tb_mem_arbiter_n;
   localparam int unsigned MB = 16;
   localparam int unsigned LW = 5;
   localparam int unsigned DW = MB * 8;

   logic clk = 1'b0;
   logic rst, rdy, io_full;

   logic [7:0]      mem_din, mem_dout;
   logic [31:0]     mem_a;
   logic            mem_wr;
   logic [1:0]      req, wr, cancel, done;
   logic [63:0]     addr;
   logic [2*LW-1:0] len;
   logic [2*DW-1:0] wdata;
   logic [DW-1:0]   rdata;

   logic [7:0]      rr_din, rr_dout;
   logic [31:0]     rr_a;
   logic            rr_mem_wr;
   logic [2:0]      rr_req, rr_wr, rr_cancel, rr_done;
   logic [95:0]     rr_addr;
   logic [3*LW-1:0] rr_len;
   logic [3*DW-1:0] rr_wdata;
   logic [DW-1:0]   rr_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            ch;
      bit            is_rd;
      logic [DW-1:0] rd;
   } exp_t;
   exp_t sb[$];

   mem_arbiter_n #(.NUM_CH(2), .MAX_BYTES(MB), .LEN_W(LW), .ARB_RR(0)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full), .ch_req(req),
      .ch_wr(wr), .ch_cancel(cancel), .ch_addr(addr), .ch_len(len), .ch_wdata(wdata),
      .ch_done(done), .ch_rdata(rdata));

   mem_arbiter_n #(.NUM_CH(3), .MAX_BYTES(MB), .LEN_W(LW), .ARB_RR(1)) dut_rr (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(rr_din), .mem_dout(rr_dout),
      .mem_a(rr_a), .mem_wr(rr_mem_wr), .io_buffer_full(io_full), .ch_req(rr_req),
      .ch_wr(rr_wr), .ch_cancel(rr_cancel), .ch_addr(rr_addr), .ch_len(rr_len),
      .ch_wdata(rr_wdata), .ch_done(rr_done), .ch_rdata(rr_rdata));

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [9:0] a);
      return (a == 10'h020) ? 8'h7F : 8'(int'(a) * 13 + 5);
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [31:0] a, input int n);
      logic [DW-1:0] r;
      logic [31:0]   ak;
      r = '0;
      for (int k = 0; k < n; k++) begin
         ak = a + 32'(k);
         r[k*8 +: 8] = ram_byte(ak[9:0]);
      end
      return r;
   endfunction

   // RAM answers the address of the previous cycle
   always @(posedge clk) begin
      mem_din <= ram_byte(mem_a[9:0]);
      rr_din  <= ram_byte(rr_a[9:0]);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ch(input int c, input logic w, input logic [31:0] a,
                         input logic [LW-1:0] l, input logic [DW-1:0] d);
      wr[c]              = w;
      addr[c*32 +: 32]   = a;
      len[c*LW +: LW]    = l;
      wdata[c*DW +: DW]  = d;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done == 2'b00 && n < bound);
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; io_full = 1'b0;
      req = '0; wr = '0; cancel = '0; addr = '0; len = '0; wdata = '0;
      rr_req = '0; rr_wr = '0; rr_cancel = '0; rr_addr = '0; rr_len = '0; rr_wdata = '0;
      repeat (3) tick();
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
      checks++; if (mem_wr !== 1'b0 || mem_dout !== 8'h0) begin errors++; $display("FAIL reset_wr_dout: got %b/%h expected 0/00", mem_wr, mem_dout); end
      checks++; if (done !== 2'b00 || rdata !== '0) begin errors++; $display("FAIL reset_done_rdata: got %b/%h expected 0/0", done, rdata); end
      checks++; if (rr_a !== 32'h0 || rr_mem_wr !== 1'b0 || rr_done !== 3'b000) begin errors++; $display("FAIL reset_rr: got %h/%b/%b expected 0/0/0", rr_a, rr_mem_wr, rr_done); end
      rst = 1'b0;
      tick();
   endtask

   // Fixed priority: ch0 write first, ch1 16-byte read granted right after ch0's done bubble
   task automatic test_priority_write_read();
      logic [7:0] wb [4];
      exp_t e;
      int n;
      wb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      set_ch(0, 1'b1, 32'h100, LW'(4), DW'(32'hDDCCBBAA));
      set_ch(1, 1'b0, 32'h0, LW'(16), '0);
      req = 2'b11;
      sb.push_back('{ch: 0, is_rd: 1'b0, rd: '0});
      sb.push_back('{ch: 1, is_rd: 1'b1, rd: exp_rd(32'h0, 16)});
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (mem_wr !== 1'b1 || mem_a !== 32'h100 + 32'(k - 1) || mem_dout !== wb[k-1] || done !== 2'b00) begin
            errors++;
            $display("FAIL write_byte%0d: got wr=%b a=%h d=%h done=%b expected wr=1 a=%h d=%h done=00",
                     k - 1, mem_wr, mem_a, mem_dout, done, 32'h100 + 32'(k - 1), wb[k-1]);
         end
         if (k == 1) set_ch(0, 1'b1, 32'hBAD0, LW'(4), '1);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (done !== 2'(1 << e.ch) || mem_a !== 32'h0 || mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL write_done: got done=%b a=%h wr=%b expected done=%b a=0 wr=0", done, mem_a, mem_wr, 2'(1 << e.ch));
      end
      req[0] = 1'b0;
      wait_done(40, n);
      e = sb.pop_front();
      checks++; if (n !== 19) begin errors++; $display("FAIL read16_latency: got %0d expected 19", n); end
      checks++;
      if (done !== 2'(1 << e.ch) || rdata !== e.rd) begin
         errors++;
         $display("FAIL read16_data: got done=%b rdata=%h expected done=%b rdata=%h", done, rdata, 2'(1 << e.ch), e.rd);
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_read_one();
      exp_t e;
      int n;
      set_ch(0, 1'b0, 32'h20, LW'(1), '0);
      req = 2'b01;
      sb.push_back('{ch: 0, is_rd: 1'b1, rd: DW'(8'h7F)});
      tick();
      checks++; if (mem_a !== 32'h20 || mem_wr !== 1'b0) begin errors++; $display("FAIL read1_addr: got a=%h wr=%b expected 00000020/0", mem_a, mem_wr); end
      wait_done(10, n);
      e = sb.pop_front();
      checks++; if (n !== 2) begin errors++; $display("FAIL read1_latency: got %0d expected 2", n); end
      checks++;
      if (done !== 2'(1 << e.ch) || rdata !== e.rd) begin
         errors++;
         $display("FAIL read1_data: got done=%b rdata=%h expected done=%b rdata=%h", done, rdata, 2'(1 << e.ch), e.rd);
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_io_stall();
      exp_t e;
      int n;
      set_ch(1, 1'b1, 32'h30000, LW'(1), DW'(8'h5A));
      req = 2'b10;
      io_full = 1'b1;
      sb.push_back('{ch: 1, is_rd: 1'b0, rd: '0});
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (mem_wr !== 1'b0 || mem_a !== 32'h30000 || done !== 2'b00) begin
            errors++;
            $display("FAIL io_stall_c%0d: got wr=%b a=%h done=%b expected wr=0 a=00030000 done=00", k, mem_wr, mem_a, done);
         end
      end
      io_full = 1'b0;
      tick();
      checks++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h5A) begin
         errors++;
         $display("FAIL io_issue: got wr=%b a=%h d=%h expected wr=1 a=00030000 d=5a", mem_wr, mem_a, mem_dout);
      end
      wait_done(10, n);
      e = sb.pop_front();
      checks++;
      if (n !== 1 || done !== 2'(1 << e.ch)) begin
         errors++;
         $display("FAIL io_done: got n=%0d done=%b expected n=1 done=%b", n, done, 2'(1 << e.ch));
      end
      req = 2'b00;
      tick();
   endtask

   // Cancel ch1 two cycles into a 16-byte read; ch0 (non-IO write, UART full) takes over
   task automatic test_cancel();
      exp_t e;
      int n;
      set_ch(1, 1'b0, 32'h0, LW'(16), '0);
      req = 2'b10;
      tick();
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL cancel_a0: got %h expected 0", mem_a); end
      tick();
      checks++; if (mem_a !== 32'h1) begin errors++; $display("FAIL cancel_a1: got %h expected 1", mem_a); end
      cancel = 2'b10;
      req = 2'b01;
      io_full = 1'b1;
      set_ch(0, 1'b1, 32'h200, LW'(2), DW'(16'h2211));
      sb.push_back('{ch: 0, is_rd: 1'b0, rd: '0});
      tick();
      checks++;
      if (mem_a !== 32'h0 || mem_wr !== 1'b0 || done !== 2'b00) begin
         errors++;
         $display("FAIL cancel_abort: got a=%h wr=%b done=%b expected 0/0/00", mem_a, mem_wr, done);
      end
      cancel = 2'b00;
      tick();
      checks++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h200 || mem_dout !== 8'h11) begin
         errors++;
         $display("FAIL cancel_next_grant: got wr=%b a=%h d=%h expected 1/00000200/11", mem_wr, mem_a, mem_dout);
      end
      wait_done(10, n);
      e = sb.pop_front();
      checks++;
      if (n !== 2 || done !== 2'(1 << e.ch)) begin
         errors++;
         $display("FAIL cancel_done: got n=%0d done=%b expected n=2 done=%b", n, done, 2'(1 << e.ch));
      end
      io_full = 1'b0;
      req = 2'b00;
      tick();
   endtask

   task automatic test_boundaries();
      exp_t e;
      int n;
      set_ch(1, 1'b1, 32'h300, LW'(0), '1);
      req = 2'b10;
      tick();
      checks++;
      if (done !== 2'b10 || mem_wr !== 1'b0 || mem_a !== 32'h0) begin
         errors++;
         $display("FAIL len0_write: got done=%b wr=%b a=%h expected 10/0/0", done, mem_wr, mem_a);
      end
      req = 2'b00;
      tick();
      set_ch(0, 1'b0, 32'h40, LW'(20), '0);
      req = 2'b01;
      sb.push_back('{ch: 0, is_rd: 1'b1, rd: exp_rd(32'h40, 16)});
      wait_done(40, n);
      e = sb.pop_front();
      checks++; if (n !== 18) begin errors++; $display("FAIL clamp_latency: got %0d expected 18", n); end
      checks++; if (rdata !== e.rd) begin errors++; $display("FAIL clamp_data: got %h expected %h", rdata, e.rd); end
      req = 2'b00;
      tick();
      set_ch(0, 1'b0, 32'hFFFF_FFFF, LW'(2), '0);
      req = 2'b01;
      sb.push_back('{ch: 0, is_rd: 1'b1, rd: exp_rd(32'hFFFF_FFFF, 2)});
      tick();
      checks++; if (mem_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_a0: got %h expected ffffffff", mem_a); end
      tick();
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap_a1: got %h expected 0", mem_a); end
      wait_done(10, n);
      e = sb.pop_front();
      checks++;
      if (n !== 2 || rdata !== e.rd) begin
         errors++;
         $display("FAIL wrap_data: got n=%0d rdata=%h expected n=2 rdata=%h", n, rdata, e.rd);
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   seen;
      bit   saw_wr;
      seen = 0;
      saw_wr = 1'b0;
      rr_addr = {32'h12, 32'h11, 32'h10};
      rr_len  = {LW'(0), LW'(1), LW'(1)};
      sb.push_back('{ch: 0, is_rd: 1'b1, rd: exp_rd(32'h10, 1)});
      sb.push_back('{ch: 1, is_rd: 1'b1, rd: exp_rd(32'h11, 1)});
      sb.push_back('{ch: 2, is_rd: 1'b1, rd: '0});
      sb.push_back('{ch: 0, is_rd: 1'b1, rd: exp_rd(32'h10, 1)});
      rr_req = 3'b111;
      for (int c = 0; c < 60 && seen < 4; c++) begin
         tick();
         if (rr_mem_wr !== 1'b0) saw_wr = 1'b1;
         if (rr_done !== 3'b000) begin
            e = sb.pop_front();
            seen++;
            checks++;
            if (rr_done !== 3'(1 << e.ch) || rr_rdata !== e.rd) begin
               errors++;
               $display("FAIL rr_grant%0d: got done=%b rdata=%h expected done=%b rdata=%h",
                        seen, rr_done, rr_rdata, 3'(1 << e.ch), e.rd);
            end
            if (e.ch == 2) begin
               checks++;
               if (rr_a !== 32'h0) begin errors++; $display("FAIL rr_len0_addr: got %h expected 0", rr_a); end
            end
         end
      end
      rr_req = 3'b000;
      checks++; if (seen !== 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", seen); end
      checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL rr_no_write: got %b expected 0", saw_wr); end
      sb.delete();
      tick();
   endtask

   initial begin
      test_reset();
      test_priority_write_read();
      test_read_one();
      test_io_stall();
      test_cancel();
      test_boundaries();
      test_round_robin();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
